// File: rtl/gpr_file_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gpr_file_mp_if                                         |
// | Description : Read / write / claim bundle of the multi-port GPR file |
// |               (decode-side master, register-file-side slave).        |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
interface gpr_file_mp_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1
);
  localparam int AW = $clog2(NREG);

  logic [NRD-1:0]      rd_en;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                claim_en;
  logic [AW-1:0]       claim_addr;
  logic [NREG-1:0]     busy_vec;

  modport master (
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    input  rd_data, rd_busy, busy_vec
  );

  modport slave (
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, claim_en, claim_addr,
    output rd_data, rd_busy, busy_vec
  );
endinterface
`default_nettype wire

// File: rtl/gpr_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : gpr_file_mp                                            |
// | Description : Multi-port GPR file, synchronous reads, r0 == 0, with  |
// |               per-register busy scoreboard (claim / release).        |
// |               Optional macro GPR_BYPASS_EN: write-first forwarding   |
// |               of same-edge writes/claims to the read ports.          |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module gpr_file_mp #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 1
) (
  input  wire             clk,
  input  wire             rstn_h,
  gpr_file_mp_if.slave    bus
);
  localparam int AW = $clog2(NREG);

  // Register 0 has no storage: arrays start at index 1.
  logic [XLEN-1:0]     regs_q [1:NREG-1];
  logic [XLEN-1:0]     regs_d [1:NREG-1];
  logic [NREG-1:1]     busy_q;
  logic [NREG-1:1]     busy_d;
  logic [NRD*XLEN-1:0] rd_data_q;
  logic [NRD*XLEN-1:0] rd_data_d;
  logic [NRD-1:0]      rd_busy_q;
  logic [NRD-1:0]      rd_busy_d;
  logic [AW-1:0]       wa;
  logic [AW-1:0]       ra;

  // Next register/busy state: writes in port order (highest index wins),
  // write releases busy, then claim overrides release.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    wa     = '0;
    for (int j = 0; j < NWR; j++) begin
      wa = bus.wr_addr[j*AW +: AW];
      if (bus.wr_en[j] && (wa != '0)) begin
        regs_d[wa] = bus.wr_data[j*XLEN +: XLEN];
        busy_d[wa] = 1'b0;
      end
    end
    if (bus.claim_en && (bus.claim_addr != '0)) begin
      busy_d[bus.claim_addr] = 1'b1;
    end
  end

  // Read ports: capture on enable, hold otherwise; r0 always reads 0 / not busy.
  always_comb begin
    rd_data_d = rd_data_q;
    rd_busy_d = rd_busy_q;
    ra        = '0;
    for (int i = 0; i < NRD; i++) begin
      ra = bus.rd_addr[i*AW +: AW];
      if (bus.rd_en[i]) begin
        if (ra == '0) begin
          rd_data_d[i*XLEN +: XLEN] = '0;
          rd_busy_d[i]              = 1'b0;
        end else begin
`ifdef GPR_BYPASS_EN
          rd_data_d[i*XLEN +: XLEN] = regs_d[ra];
          rd_busy_d[i]              = busy_d[ra];
`else
          rd_data_d[i*XLEN +: XLEN] = regs_q[ra];
          rd_busy_d[i]              = busy_q[ra];
`endif
        end
      end
    end
  end

  // State flops, asynchronously cleared.
  always_ff @(posedge clk or negedge rstn_h) begin
    if (!rstn_h) begin
      for (int k = 1; k < NREG; k++) begin
        regs_q[k] <= '0;
      end
      busy_q    <= '0;
      rd_data_q <= '0;
      rd_busy_q <= '0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      rd_data_q <= rd_data_d;
      rd_busy_q <= rd_busy_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_busy  = rd_busy_q;
  assign bus.busy_vec = {busy_q, 1'b0};
endmodule
`default_nettype wire

// File: tb/tb_gpr_file_mp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_gpr_file_mp                                         |
// | Description : Self-checking bench for gpr_file_mp (NRD=3, NWR=2).    |
// |               Expectations follow GPR_BYPASS_EN when defined.        |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_gpr_file_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 3;
  localparam int NWR  = 2;
  localparam int AW   = $clog2(NREG);

  typedef struct {
    int              port;
    logic [XLEN-1:0] data;
    logic            busy;
    string           name;
  } exp_t;

  logic clk;
  logic rstn_h;
  exp_t sb[$];
  exp_t e;
  int   vectors;
  int   errors;

  gpr_file_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bus ();

  gpr_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) dut (
    .clk    (clk),
    .rstn_h (rstn_h),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus.rd_en    = '0;
    bus.wr_en    = '0;
    bus.claim_en = 1'b0;
  endtask

  // Advance one rising edge; inputs are changed / outputs sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_write(int port, int addr, logic [XLEN-1:0] data);
    bus.wr_en[port]               = 1'b1;
    bus.wr_addr[port*AW +: AW]    = AW'(addr);
    bus.wr_data[port*XLEN +: XLEN] = data;
  endtask

  task automatic do_claim(int addr);
    bus.claim_en   = 1'b1;
    bus.claim_addr = AW'(addr);
  endtask

  // Drive a read and push its expected result for the next edge.
  task automatic do_read(int port, int addr, logic [XLEN-1:0] d, logic b, string nm);
    exp_t x;
    bus.rd_en[port]            = 1'b1;
    bus.rd_addr[port*AW +: AW] = AW'(addr);
    x.port = port; x.data = d; x.busy = b; x.name = nm;
    sb.push_back(x);
  endtask

  task automatic test_reset();
    // Power-on state
    vectors++;
    if (bus.rd_data !== '0 || bus.rd_busy !== '0 || bus.busy_vec !== '0) begin
      errors++;
      $display("FAIL por_state: rd_data=%h rd_busy=%b busy_vec=%h, expected all zero",
               bus.rd_data, bus.rd_busy, bus.busy_vec);
    end
    do_write(0, 5, 32'hDEADBEEF);
    do_claim(5);
    tick();
    vectors++;
    if (bus.busy_vec !== 32'h0000_0020) begin
      errors++;
      $display("FAIL t1_claim: busy_vec=%h expected 00000020", bus.busy_vec);
    end
    do_read(0, 5, 32'hDEADBEEF, 1'b1, "t1_pre_reset_rd");
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
    // Asynchronous reset asserted mid-cycle with a write in flight
    do_write(0, 5, 32'h1111_2222);
    #2 rstn_h = 1'b0;
    #1;
    vectors++;
    if (bus.rd_data !== '0 || bus.rd_busy !== '0 || bus.busy_vec !== '0) begin
      errors++;
      $display("FAIL t1_async_reset: rd_data=%h rd_busy=%b busy_vec=%h, expected zero",
               bus.rd_data, bus.rd_busy, bus.busy_vec);
    end
    @(posedge clk);
    #3 rstn_h = 1'b1;
    idle();
    #1;
    do_read(0, 5, 32'h0, 1'b0, "t1_post_reset_rd");
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_r0();
    do_write(1, 0, 32'hFFFFFFFF);
    do_claim(0);
    do_read(1, 0, 32'h0, 1'b0, "t2_r0_same_edge");
    tick();
    vectors++;
    if (bus.busy_vec !== '0) begin
      errors++;
      $display("FAIL t2_busy_vec: busy_vec=%h expected 00000000", bus.busy_vec);
    end
    do_read(0, 0, 32'h0, 1'b0, "t2_r0_after");
    while (sb.size() > 1) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_latency_hold();
    do_write(0, 3, 32'h12);
    tick();
    do_read(0, 3, 32'h12, 1'b0, "t3_latency");
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
    do_write(0, 3, 32'h34);
    tick();
    vectors++;
    if (bus.rd_data[0 +: XLEN] !== 32'h12) begin
      errors++;
      $display("FAIL t3_hold: rd_data0=%h expected 00000012", bus.rd_data[0 +: XLEN]);
    end
    do_read(2, 3, 32'h34, 1'b0, "t3_new_value");
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_same_edge();
    do_write(0, 7, 32'h1);
    tick();
    do_write(0, 7, 32'h2);
`ifdef GPR_BYPASS_EN
    do_read(0, 7, 32'h2, 1'b0, "t4_same_edge_bypass");
`else
    do_read(0, 7, 32'h1, 1'b0, "t4_same_edge_readfirst");
`endif
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
    do_read(0, 7, 32'h2, 1'b0, "t4_next_read");
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_write_collision();
    do_write(0, 9, 32'hA);
    do_write(1, 9, 32'hB);
    tick();
    do_read(1, 9, 32'hB, 1'b0, "t5_collision");
    // Highest boundary register as well
    do_write(0, NREG-1, 32'hCAFE_0001);
    tick();
    do_read(0, NREG-1, 32'hCAFE_0001, 1'b0, "t5_top_reg");
    while (sb.size() > 1) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
  endtask

  task automatic test_scoreboard();
    logic [XLEN-1:0] d0;
    do_claim(4);
    tick();
    vectors++;
    if (bus.busy_vec !== 32'h0000_0010) begin
      errors++;
      $display("FAIL t6_claim: busy_vec=%h expected 00000010", bus.busy_vec);
    end
    do_write(0, 4, 32'h44);
    do_claim(4);
`ifdef GPR_BYPASS_EN
    do_read(0, 4, 32'h44, 1'b1, "t6_rd_claim_release");
`else
    do_read(0, 4, 32'h0, 1'b1, "t6_rd_claim_release");
`endif
    tick();
    vectors++;
    if (bus.busy_vec !== 32'h0000_0010) begin
      errors++;
      $display("FAIL t6_claim_wins: busy_vec=%h expected 00000010", bus.busy_vec);
    end
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
    do_write(1, 4, 32'h55);
`ifdef GPR_BYPASS_EN
    do_read(1, 4, 32'h55, 1'b0, "t6_rd_release");
`else
    do_read(1, 4, 32'h44, 1'b1, "t6_rd_release");
`endif
    tick();
    vectors++;
    if (bus.busy_vec !== '0) begin
      errors++;
      $display("FAIL t6_release: busy_vec=%h expected 00000000", bus.busy_vec);
    end
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
    for (int p = 0; p < NRD; p++) begin
      do_read(p, 4, 32'h55, 1'b0, $sformatf("t6_all_ports_p%0d", p));
    end
    tick();
    while (sb.size() != 0) begin
      e = sb.pop_front(); vectors++;
      if (bus.rd_data[e.port*XLEN +: XLEN] !== e.data || bus.rd_busy[e.port] !== e.busy) begin
        errors++;
        $display("FAIL %s: got %h/%b expected %h/%b", e.name,
                 bus.rd_data[e.port*XLEN +: XLEN], bus.rd_busy[e.port], e.data, e.busy);
      end
    end
    d0 = bus.rd_data[0 +: XLEN];
    vectors++;
    if (bus.rd_data[XLEN +: XLEN] !== d0 || bus.rd_data[2*XLEN +: XLEN] !== d0) begin
      errors++;
      $display("FAIL t6_ports_identical: rd_data=%h expected three copies of %h",
               bus.rd_data, d0);
    end
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rstn_h  = 1'b0;
    bus.rd_en      = '0;
    bus.rd_addr    = '0;
    bus.wr_en      = '0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.claim_en   = 1'b0;
    bus.claim_addr = '0;
    repeat (2) @(posedge clk);
    #3 rstn_h = 1'b1;
    #1;
    test_reset();
    test_r0();
    test_latency_hold();
    test_same_edge();
    test_write_collision();
    test_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
`default_nettype wire
